// File: rtl/y86_dmem_responder.sv
// Multi-cycle data-memory responder for the Y86-64 core: one 8-byte little-endian
// access at a time, serviced LATENCY edges after acceptance, valid/ready on both sides.
module y86_dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int             AW       = $clog2(MEM_BYTES);
    localparam int             CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0]    LAST_OK  = 64'(MEM_BYTES - 8);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [63:0]     r_addr, r_wdata;
    logic [63:0]     r_rdata;
    logic            r_err;
    logic [7:0]      r_mem [MEM_BYTES];

    logic            w_accept, w_commit, w_err;
    logic [AW-1:0]   w_base;
    logic [63:0]     w_rdata;

    // Full 64-bit compare so addresses near 2^64 never alias into storage
    assign w_err  = (r_addr > LAST_OK);
    assign w_base = r_addr[AW-1:0];

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < 8; k++)
            w_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: if (req_valid) begin
                w_next   = S_BUSY;
                w_accept = 1'b1;
            end
            S_BUSY: if (r_cnt == '0) begin
                w_next   = S_RESP;
                w_commit = 1'b1;
            end
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so it reads 0 throughout reset, not just after it
    assign req_ready = rst_n && (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (r_write || w_err) ? '0 : w_rdata;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; a reset before the commit edge leaves state IDLE so nothing lands
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            for (int k = 0; k < 8; k++)
                r_mem[w_base + AW'(k)] <= r_wdata[8*k +: 8];
        end
    end

endmodule
